// File: rtl/fsm_control_param_if.sv
// Handshake/status bundle between the PCIe TX control FSM and its FIFOs.
// The FIFO side drives the master modport; the controller uses slave.
interface fsm_control_param_if #(
    parameter int NUM_VC = 2,
    parameter int NUM_D  = 2,
    parameter int U_MFS  = 4,
    parameter int U_VCS  = 4,
    parameter int U_DS   = 4,
    parameter int CNT_W  = 4
);
    logic                   init;
    logic [U_MFS-1:0]       umbral_MFs;
    logic [U_VCS-1:0]       umbral_VCs;
    logic [U_DS-1:0]        umbral_Ds;
    logic                   empty_main_fifo;
    logic [NUM_VC-1:0]      empty_fifo_VC;
    logic [NUM_D-1:0]       empty_fifo_D;
    logic                   error_main;
    logic [NUM_VC-1:0]      error_VC;
    logic [NUM_D-1:0]       error_D;

    logic [2:0]             present_state;
    logic [2:0]             next_state;
    logic                   error_out;
    logic                   active_out;
    logic                   idle_out;
    logic [U_MFS-1:0]       umbral_MFs_out;
    logic [U_VCS-1:0]       umbral_VCs_out;
    logic [U_DS-1:0]        umbral_Ds_out;
    logic [NUM_VC+NUM_D:0]  error_src;
    logic [CNT_W-1:0]       error_count;

    modport master (
        output init, umbral_MFs, umbral_VCs, umbral_Ds,
        output empty_main_fifo, empty_fifo_VC, empty_fifo_D,
        output error_main, error_VC, error_D,
        input  present_state, next_state,
        input  error_out, active_out, idle_out,
        input  umbral_MFs_out, umbral_VCs_out, umbral_Ds_out,
        input  error_src, error_count
    );

    modport slave (
        input  init, umbral_MFs, umbral_VCs, umbral_Ds,
        input  empty_main_fifo, empty_fifo_VC, empty_fifo_D,
        input  error_main, error_VC, error_D,
        output present_state, next_state,
        output error_out, active_out, idle_out,
        output umbral_MFs_out, umbral_VCs_out, umbral_Ds_out,
        output error_src, error_count
    );
endinterface

// File: rtl/fsm_control_param.sv
// Parametrised PCIe TX-layer control FSM: global status, threshold latch,
// ACTIVE->IDLE hysteresis, sticky error sources and saturating error count.
module fsm_control_param #(
    parameter int NUM_VC    = 2,
    parameter int NUM_D     = 2,
    parameter int U_MFS     = 4,
    parameter int U_VCS     = 4,
    parameter int U_DS      = 4,
    parameter int IDLE_HOLD = 2,
    parameter int CNT_W     = 4
) (
    input logic                 clk,
    input logic                 reset,
    fsm_control_param_if.slave  bus
);

    typedef enum logic [2:0] {
        RESET  = 3'd0,
        INIT   = 3'd1,
        IDLE   = 3'd2,
        ACTIVE = 3'd3,
        ERROR  = 3'd4
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(IDLE_HOLD - 1);

    state_t                 state;
    state_t                 nxt;
    logic [3:0]             hold;
    logic [NUM_VC+NUM_D:0]  err_vec;
    logic                   any_err;
    logic                   all_empty;

    assign err_vec   = {bus.error_D, bus.error_VC, bus.error_main};
    assign any_err   = |err_vec;
    assign all_empty = bus.empty_main_fifo
                     & (&bus.empty_fifo_VC)
                     & (&bus.empty_fifo_D);

    always_comb begin
        nxt = state;
        if (!reset) begin
            nxt = RESET;
        end else begin
            unique case (state)
                RESET: nxt = INIT;
                INIT: begin
                    if (any_err)        nxt = ERROR;
                    else if (!bus.init) nxt = IDLE;
                    else                nxt = INIT;
                end
                IDLE: begin
                    if (any_err)         nxt = ERROR;
                    else if (bus.init)   nxt = INIT;
                    else if (!all_empty) nxt = ACTIVE;
                    else                 nxt = IDLE;
                end
                ACTIVE: begin
                    if (any_err)       nxt = ERROR;
                    else if (bus.init) nxt = INIT;
                    else if (all_empty && hold == HOLD_LAST)
                        nxt = IDLE;
                    else               nxt = ACTIVE;
                end
                ERROR: begin
                    if (bus.init && !any_err) nxt = INIT;
                    else                      nxt = ERROR;
                end
                default: nxt = RESET;
            endcase
        end
    end

    assign bus.next_state    = nxt;
    assign bus.present_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= RESET;
            hold               <= 4'd0;
            bus.error_out      <= 1'b0;
            bus.active_out     <= 1'b0;
            bus.idle_out       <= 1'b0;
            bus.umbral_MFs_out <= {U_MFS{1'b0}};
            bus.umbral_VCs_out <= {U_VCS{1'b0}};
            bus.umbral_Ds_out  <= {U_DS{1'b0}};
            bus.error_src      <= '0;
            bus.error_count    <= {CNT_W{1'b0}};
        end else begin
            state          <= nxt;
            bus.error_out  <= (nxt == ERROR);
            bus.active_out <= (nxt == ACTIVE);
            bus.idle_out   <= (nxt == IDLE);

            if (state == INIT) begin
                bus.umbral_MFs_out <= bus.umbral_MFs;
                bus.umbral_VCs_out <= bus.umbral_VCs;
                bus.umbral_Ds_out  <= bus.umbral_Ds;
            end

            // Hold counter only runs while staying in ACTIVE.
            if (state == ACTIVE && nxt == ACTIVE)
                hold <= all_empty ? hold + 4'd1 : 4'd0;
            else
                hold <= 4'd0;

            if (nxt == ERROR && state != ERROR &&
                bus.error_count != {CNT_W{1'b1}})
                bus.error_count <= bus.error_count + CNT_W'(1);

            if (nxt == ERROR)
                bus.error_src <= bus.error_src | err_vec;
            else if (state == ERROR)
                bus.error_src <= '0;
        end
    end

endmodule

// File: tb/tb_fsm_control_param.sv
// Directed bench for fsm_control_param: default build plus a
// NUM_VC=4/NUM_D=3 build to exercise the wider error_src vector.
module tb_fsm_control_param;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   vectors;
    int   errs;

    fsm_control_param_if #(
        .NUM_VC(2), .NUM_D(2), .U_MFS(4), .U_VCS(4), .U_DS(4), .CNT_W(4)
    ) bus_a ();

    fsm_control_param_if #(
        .NUM_VC(4), .NUM_D(3), .U_MFS(4), .U_VCS(4), .U_DS(4), .CNT_W(4)
    ) bus_b ();

    fsm_control_param #(
        .NUM_VC(2), .NUM_D(2), .U_MFS(4), .U_VCS(4), .U_DS(4),
        .IDLE_HOLD(2), .CNT_W(4)
    ) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    fsm_control_param #(
        .NUM_VC(4), .NUM_D(3), .U_MFS(4), .U_VCS(4), .U_DS(4),
        .IDLE_HOLD(2), .CNT_W(4)
    ) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [2:0] st,
                         input logic [3:0] cnt, input logic [4:0] src);
        chk({tag, ".state"}, 32'(bus_a.present_state), 32'(st));
        chk({tag, ".idle"}, 32'(bus_a.idle_out), 32'(st == 3'd2));
        chk({tag, ".active"}, 32'(bus_a.active_out), 32'(st == 3'd3));
        chk({tag, ".error"}, 32'(bus_a.error_out), 32'(st == 3'd4));
        chk({tag, ".count"}, 32'(bus_a.error_count), 32'(cnt));
        chk({tag, ".src"}, 32'(bus_a.error_src), 32'(src));
    endtask

    task automatic chk_umb(input string tag, input logic [3:0] m,
                           input logic [3:0] v, input logic [3:0] d);
        chk({tag, ".umb_m"}, 32'(bus_a.umbral_MFs_out), 32'(m));
        chk({tag, ".umb_v"}, 32'(bus_a.umbral_VCs_out), 32'(v));
        chk({tag, ".umb_d"}, 32'(bus_a.umbral_Ds_out), 32'(d));
    endtask

    initial begin
        logic [3:0] exp_cnt;
        vectors = 0;
        errs    = 0;

        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.init            = 1'b1;
        bus_a.umbral_MFs      = 4'hE;
        bus_a.umbral_VCs      = 4'h7;
        bus_a.umbral_Ds       = 4'h9;
        bus_a.empty_main_fifo = 1'b1;
        bus_a.empty_fifo_VC   = 2'b11;
        bus_a.empty_fifo_D    = 2'b11;
        bus_a.error_main      = 1'b0;
        bus_a.error_VC        = 2'b00;
        bus_a.error_D         = 2'b00;
        bus_b.init            = 1'b0;
        bus_b.umbral_MFs      = 4'h3;
        bus_b.umbral_VCs      = 4'h3;
        bus_b.umbral_Ds       = 4'h3;
        bus_b.empty_main_fifo = 1'b1;
        bus_b.empty_fifo_VC   = 4'hF;
        bus_b.empty_fifo_D    = 3'h7;
        bus_b.error_main      = 1'b0;
        bus_b.error_VC        = 4'h0;
        bus_b.error_D         = 3'h0;

        // Reset held for two cycles.
        tick();
        tick();
        chk_a("rst", 3'd0, 4'd0, 5'd0);
        chk_umb("rst", 4'h0, 4'h0, 4'h0);
        chk("rst.next", 32'(bus_a.next_state), 32'd0);

        rst_a = 1'b1;
        #1;
        chk("rel.next", 32'(bus_a.next_state), 32'd1);
        tick();
        chk_a("init0", 3'd1, 4'd0, 5'd0);
        chk_umb("init0", 4'h0, 4'h0, 4'h0);
        tick();
        chk_umb("init1", 4'hE, 4'h7, 4'h9);

        bus_a.umbral_MFs = 4'h1;
        bus_a.umbral_VCs = 4'h1;
        bus_a.umbral_Ds  = 4'h1;
        tick();
        chk_umb("init2", 4'h1, 4'h1, 4'h1);

        bus_a.init = 1'b0;
        tick();
        chk_a("idle0", 3'd2, 4'd0, 5'd0);

        // Thresholds must hold outside INIT.
        bus_a.umbral_MFs = 4'h5;
        bus_a.empty_fifo_VC = 2'b10;
        #1;
        chk("idle.next", 32'(bus_a.next_state), 32'd3);
        tick();
        chk_a("act0", 3'd3, 4'd0, 5'd0);
        chk_umb("hold", 4'h1, 4'h1, 4'h1);

        bus_a.empty_fifo_VC = 2'b11;
        tick();
        chk_a("act1", 3'd3, 4'd0, 5'd0);
        tick();
        chk_a("act2", 3'd2, 4'd0, 5'd0);

        // Error capture from ACTIVE.
        bus_a.empty_fifo_D = 2'b01;
        tick();
        chk_a("act3", 3'd3, 4'd0, 5'd0);
        bus_a.error_main = 1'b1;
        tick();
        chk_a("err0", 3'd4, 4'd1, 5'b00001);
        bus_a.error_D = 2'b10;
        tick();
        chk_a("err1", 3'd4, 4'd1, 5'b10001);
        bus_a.error_D = 2'b00;

        bus_a.init = 1'b1;
        tick();
        chk_a("err2", 3'd4, 4'd1, 5'b10001);
        bus_a.error_main = 1'b0;
        tick();
        chk_a("rec0", 3'd1, 4'd1, 5'b00000);
        bus_a.init = 1'b0;
        bus_a.empty_fifo_D = 2'b11;
        tick();
        chk_a("rec1", 3'd2, 4'd1, 5'b00000);

        // Error beats init in IDLE.
        bus_a.error_VC = 2'b10;
        bus_a.init = 1'b1;
        tick();
        chk_a("pri0", 3'd4, 4'd2, 5'b00100);

        exp_cnt = 4'd2;
        for (int i = 0; i < 15; i++) begin
            bus_a.error_VC = 2'b00;
            tick();
            chk("sat.init", 32'(bus_a.present_state), 32'd1);
            bus_a.error_VC = 2'b10;
            tick();
            if (exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
            chk("sat.cnt", 32'(bus_a.error_count), 32'(exp_cnt));
        end
        chk_a("sat", 3'd4, 4'hF, 5'b00100);

        bus_a.error_VC = 2'b00;
        tick();
        bus_a.init = 1'b0;
        tick();
        chk_a("sat.idle", 3'd2, 4'hF, 5'b00000);

        // Asynchronous reset between edges while ACTIVE.
        bus_a.empty_main_fifo = 1'b0;
        tick();
        chk_a("pre.ar", 3'd3, 4'hF, 5'b00000);
        #2;
        rst_a = 1'b0;
        #1;
        chk_a("ar", 3'd0, 4'd0, 5'd0);
        chk_umb("ar", 4'h0, 4'h0, 4'h0);
        chk("ar.next", 32'(bus_a.next_state), 32'd0);

        // Wider build: error_src is 8 bits.
        rst_b = 1'b1;
        tick();
        chk("b.init", 32'(bus_b.present_state), 32'd1);
        tick();
        chk("b.idle", 32'(bus_b.present_state), 32'd2);
        bus_b.error_D = 3'b100;
        tick();
        chk("b.err", 32'(bus_b.present_state), 32'd4);
        chk("b.src0", 32'(bus_b.error_src), 32'h80);
        chk("b.cnt", 32'(bus_b.error_count), 32'd1);
        bus_b.error_D  = 3'b000;
        bus_b.error_VC = 4'b1000;
        tick();
        chk("b.src1", 32'(bus_b.error_src), 32'h90);
        chk("b.cnt1", 32'(bus_b.error_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
